// File: rtl/mm_pkg.sv
// Shared constants and state type for the 8x8 systolic matrix-multiply block.
package mm_pkg;

   localparam int ARR_DIM = 8;
   localparam int BAR_W = 64;
   // Read latency + skew/propagation across the array + PE output register.
   localparam int DRAIN_CYC = 1 + 2 * (ARR_DIM - 1) + 1;
   localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } mm_ctrl_state_t;

endpackage

// File: rtl/mm_systolic_ctrl.sv
// Job sequencer for the systolic array: flush, stream K operand bar pairs, drain, hold result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a job command, cmd_ready high
// ST_CLEAR | one-cycle accumulator flush to the array
// ST_FEED  | issuing buffer reads at base+issue_cnt, paused by src_stall
// ST_DRAIN | waiting DRAIN_CYC cycles for the last bar to settle in the PEs
// ST_DONE  | res_valid held until res_ack
module mm_systolic_ctrl
   import mm_pkg::*;
#(
   parameter int K_W = 10,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [K_W-1:0]    cmd_k,
   input  logic [ADDR_W-1:0] cmd_a_base,
   input  logic [ADDR_W-1:0] cmd_b_base,
   input  logic              src_stall,
   output logic              a_rd_en,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic [ADDR_W-1:0] b_rd_addr,
   input  logic [BAR_W-1:0]  a_rd_data,
   input  logic [BAR_W-1:0]  b_rd_data,
   output logic [BAR_W-1:0]  row_bar,
   output logic [BAR_W-1:0]  col_bar,
   output logic              bar_valid,
   output logic              flush,
   output logic              res_valid,
   input  logic              res_ack,
   output logic              busy
);

   mm_ctrl_state_t     state;
   logic [K_W-1:0]     k_lat;
   logic [K_W-1:0]     issue_cnt;
   logic [ADDR_W-1:0]  a_base;
   logic [ADDR_W-1:0]  b_base;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               rd_en;

   // Reads react to src_stall in the same cycle, so the strobe is decoded from state.
   assign rd_en     = (state == ST_FEED) && !src_stall;
   assign a_rd_en   = rd_en;
   assign b_rd_en   = rd_en;
   assign a_rd_addr = a_base + ADDR_W'(issue_cnt);
   assign b_rd_addr = b_base + ADDR_W'(issue_cnt);
   assign row_bar   = a_rd_data;
   assign col_bar   = b_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         k_lat     <= '0;
         issue_cnt <= '0;
         a_base    <= '0;
         b_base    <= '0;
         drain_cnt <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         flush     <= 1'b0;
         bar_valid <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         flush     <= 1'b0;
         bar_valid <= rd_en;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  k_lat     <= cmd_k;
                  a_base    <= cmd_a_base;
                  b_base    <= cmd_b_base;
                  issue_cnt <= '0;
                  flush     <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (k_lat != '0) begin
                  state <= ST_FEED;
               end else begin
                  drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
                  state     <= ST_DRAIN;
               end
            end
            ST_FEED: begin
               if (!src_stall) begin
                  issue_cnt <= issue_cnt + K_W'(1);
                  if (issue_cnt == k_lat - K_W'(1)) begin
                     drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
                     state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  res_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            ST_DONE: begin
               if (res_ack) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               res_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
